// File: rtl/ssd_scan_arbiter_if.sv
// Display bundle between the requesters (master side) and the scan arbiter (slave side).
interface ssd_scan_arbiter_if;
    logic [31:0] data_a;
    logic [7:0]  dp_a;
    logic [31:0] data_b;
    logic [7:0]  dp_b;
    logic        req_b;
    logic [7:0]  digit_en;
    logic        grant_a;
    logic        grant_b;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    modport master (
        output data_a, dp_a, data_b, dp_b, req_b, digit_en,
        input  grant_a, grant_b, an, seg, frame_done
    );

    modport slave (
        input  data_a, dp_a, data_b, dp_b, req_b, digit_en,
        output grant_a, grant_b, an, seg, frame_done
    );
endinterface

// File: rtl/ssd_scan_arbiter.sv
// Seven-segment scan controller sharing the 8-digit display between requesters A and B.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN darkens leading-zero digits of the owner.
module ssd_scan_arbiter #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int HOLD_FRAMES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    ssd_scan_arbiter_if.slave bus
);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);

    localparam logic [2:0]        LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(HOLD_FRAMES);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]        state;
    logic [2:0]        idx;
    logic [CNT_W-1:0]  cnt;
    logic              owner_b;
    logic [HOLD_W-1:0] hold_cnt;

    logic              last_blank;
    logic              last_drive;
    logic              frame_end;
    logic [31:0]       own_data;
    logic [7:0]        own_dp;
    logic [3:0]        nib;
    logic              dp_bit;
    logic              lz_keep;
    logic              show;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'b0000001;
            4'h1:    hex_to_seg = 7'b1001111;
            4'h2:    hex_to_seg = 7'b0010010;
            4'h3:    hex_to_seg = 7'b0000110;
            4'h4:    hex_to_seg = 7'b1001100;
            4'h5:    hex_to_seg = 7'b0100100;
            4'h6:    hex_to_seg = 7'b0100000;
            4'h7:    hex_to_seg = 7'b0001111;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0000100;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b1100000;
            4'hC:    hex_to_seg = 7'b0110001;
            4'hD:    hex_to_seg = 7'b1000010;
            4'hE:    hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    assign last_blank = (state == ST_BLANK) && (cnt == BLANK_LAST);
    assign last_drive = (state == ST_DRIVE) && (cnt == DRIVE_LAST);
    assign frame_end  = last_drive && (idx == LAST_IDX);

    // Scan sequencer: BLANK then DRIVE for each digit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= 3'd0;
            cnt   <= '0;
        end else if (state == ST_BLANK) begin
            if (last_blank) begin
                state <= ST_DRIVE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            if (last_drive) begin
                state <= ST_BLANK;
                cnt   <= '0;
                idx   <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Ownership only moves on the last DRIVE cycle of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_b  <= 1'b0;
            hold_cnt <= '0;
        end else if (frame_end) begin
            if (!owner_b) begin
                if (bus.req_b) begin
                    owner_b  <= 1'b1;
                    hold_cnt <= '0;
                end
            end else begin
                if (!bus.req_b && (int'(hold_cnt) + 1 >= HOLD_FRAMES))
                    owner_b <= 1'b0;
                if (hold_cnt != HOLD_SAT)
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        own_data = owner_b ? bus.data_b : bus.data_a;
        own_dp   = owner_b ? bus.dp_b : bus.dp_a;
        nib      = own_data[{idx, 2'b00} +: 4];
        dp_bit   = own_dp[idx];
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [7:0] nz_from;
    logic       nz_acc;

    // nz_from[i]: some scanned nibble at index >= i is nonzero
    always_comb begin
        nz_acc  = 1'b0;
        nz_from = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS && own_data[i*4 +: 4] != 4'h0)
                nz_acc = 1'b1;
            nz_from[i] = nz_acc;
        end
    end

    assign lz_keep = (idx == 3'd0) || dp_bit || nz_from[idx];
`else
    assign lz_keep = 1'b1;
`endif

    assign show = (state == ST_DRIVE) && bus.digit_en[idx] && lz_keep;

    // Output register stage: pins trail the sequencer by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an         <= 8'hFF;
            bus.seg        <= 8'hFF;
            bus.grant_a    <= 1'b1;
            bus.grant_b    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= show ? ~(8'd1 << idx) : 8'hFF;
            bus.seg        <= show ? {hex_to_seg(nib), ~dp_bit} : 8'hFF;
            bus.grant_a    <= ~owner_b;
            bus.grant_b    <= owner_b;
            bus.frame_done <= (state == ST_BLANK) && (cnt == '0) && (idx == 3'd0);
        end
    end
endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Bench for ssd_scan_arbiter: directed scenarios plus random traffic against a position-based model.
module tb_ssd_scan_arbiter;
    localparam int ND    = 8;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int HF    = 2;
    localparam int SLOT  = BC + SD;
    localparam int FRAME = ND * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ssd_scan_arbiter_if bus();

    ssd_scan_arbiter #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: display position k counts cycles since reset release
    int         k;
    bit         m_owner_b;
    int         m_hold;
    logic [7:0] e_an, e_seg;
    logic       e_ga, e_gb, e_fd;

    always @(posedge clk) begin
        int         pos, d, o;
        logic [31:0] dat;
        logic [7:0]  dpv;
        bit          lit;
        if (rst) begin
            k = 0; m_owner_b = 0; m_hold = 0;
            e_an = 8'hFF; e_seg = 8'hFF; e_ga = 1'b1; e_gb = 1'b0; e_fd = 1'b0;
        end else begin
            pos = k % FRAME;
            d   = pos / SLOT;
            o   = pos % SLOT;
            dat = m_owner_b ? bus.data_b : bus.data_a;
            dpv = m_owner_b ? bus.dp_b : bus.dp_a;
            lit = (o >= BC) && bus.digit_en[d];
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (lit && d != 0 && !dpv[d]) begin
                lit = 0;
                for (int j = d; j < ND; j++)
                    if (dat[4*j +: 4] != 4'h0) lit = 1;
            end
`endif
            e_an  = lit ? (8'hFF ^ (8'd1 << d)) : 8'hFF;
            e_seg = lit ? {seg_tab[dat[4*d +: 4]], ~dpv[d]} : 8'hFF;
            e_fd  = (pos == 0);
            e_ga  = !m_owner_b;
            e_gb  = m_owner_b;
            if (pos == FRAME - 1) begin
                if (!m_owner_b) begin
                    if (bus.req_b) begin m_owner_b = 1; m_hold = 0; end
                end else begin
                    if (!bus.req_b && m_hold + 1 >= HF) m_owner_b = 0;
                    if (m_hold < HF) m_hold++;
                end
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("an", bus.an, e_an);
            check_eq("seg", bus.seg, e_seg);
            check_eq("grant_a", bus.grant_a, e_ga);
            check_eq("grant_b", bus.grant_b, e_gb);
            check_eq("frame_done", bus.frame_done, e_fd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just before cycle 0
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check_eq("rst_an", bus.an, 8'hFF);
        check_eq("rst_seg", bus.seg, 8'hFF);
        check_eq("rst_grant_a", bus.grant_a, 1'b1);
        check_eq("rst_grant_b", bus.grant_b, 1'b0);
        check_eq("rst_frame_done", bus.frame_done, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        bus.data_a   = 32'h0;
        bus.dp_a     = 8'h0;
        bus.data_b   = 32'h0;
        bus.dp_b     = 8'h0;
        bus.req_b    = 1'b0;
        bus.digit_en = 8'hFF;
        rst = 1'b1;
        step(1);
        chk_en = 1'b1;

        // T1: basic scan of A
        bus.data_a = 32'h0000_1234;
        do_reset();
        step(1);
        check_eq("t1_c0_fd", bus.frame_done, 1'b1);
        check_eq("t1_c0_an", bus.an, 8'hFF);
        step(1);
        check_eq("t1_c1_an", bus.an, 8'hFE);
        check_eq("t1_c1_seg", bus.seg, 8'b1001_1001);
        step(3);
        check_eq("t1_c4_an", bus.an, 8'hFE);
        step(1);
        check_eq("t1_c5_an", bus.an, 8'hFF);
        step(1);
        check_eq("t1_c6_an", bus.an, 8'hFD);
        check_eq("t1_c6_seg", bus.seg, 8'b0000_1101);
        step(34);
        check_eq("t1_c40_fd", bus.frame_done, 1'b1);

        // T2: digit 1 masked off
        bus.digit_en = 8'hFD;
        do_reset();
        step(7);
        check_eq("t2_c6_an", bus.an, 8'hFF);
        check_eq("t2_c6_seg", bus.seg, 8'hFF);
        step(4);
        check_eq("t2_c10_an", bus.an, 8'hFF);
        step(1);
        check_eq("t2_c11_an", bus.an, 8'hFB);
        check_eq("t2_c11_seg", bus.seg, 8'b0010_0101);

        // T3/T4: B request, grant, hold and release
        bus.digit_en = 8'hFF;
        bus.data_b   = 32'hFFFF_FFFF;
        do_reset();
        step(13);
        bus.req_b = 1'b1;
        step(27);
        check_eq("t3_c39_grant_a", bus.grant_a, 1'b1);
        step(1);
        check_eq("t3_c40_grant_b", bus.grant_b, 1'b1);
        step(1);
        check_eq("t3_c41_an", bus.an, 8'hFE);
        check_eq("t3_c41_seg", bus.seg, 8'b0111_0001);
        bus.req_b = 1'b0;
        step(78);
        check_eq("t4_c119_grant_b", bus.grant_b, 1'b1);
        step(1);
        check_eq("t4_c120_grant_a", bus.grant_a, 1'b1);
        check_eq("t4_c120_grant_b", bus.grant_b, 1'b0);

        // T5: reset in the middle of digit 5
        bus.data_a = 32'h8765_4321;
        step(27);
        check_eq("t5_d5_an", bus.an, 8'hDF);
        check_eq("t5_d5_seg", bus.seg, 8'b0100_0001);
        rst = 1'b1;
        step(1);
        check_eq("t5_rst_an", bus.an, 8'hFF);
        check_eq("t5_rst_seg", bus.seg, 8'hFF);
        check_eq("t5_rst_grant_a", bus.grant_a, 1'b1);
        rst = 1'b0;
        step(1);
        check_eq("t5_c0_fd", bus.frame_done, 1'b1);
        step(1);
        check_eq("t5_c1_an", bus.an, 8'hFE);
        check_eq("t5_c1_seg", bus.seg, 8'b1001_1111);

`ifdef SSD_LEADING_ZERO_BLANK_EN
        // T6: leading-zero suppression
        bus.data_a = 32'h0000_0012;
        do_reset();
        step(2);
        check_eq("t6_d0_an", bus.an, 8'hFE);
        step(5);
        check_eq("t6_d1_an", bus.an, 8'hFD);
        step(5);
        check_eq("t6_d2_an", bus.an, 8'hFF);
        bus.data_a = 32'h0;
        do_reset();
        step(2);
        check_eq("t6_zero_an", bus.an, 8'hFE);
        check_eq("t6_zero_seg", bus.seg, 8'b0000_0011);
        step(5);
        check_eq("t6_zero_d1_an", bus.an, 8'hFF);
`endif

        // Random traffic, including short req_b pulses and stray resets
        for (int s = 0; s < 60; s++) begin
            bus.data_a   = $urandom;
            bus.data_b   = $urandom;
            bus.dp_a     = 8'($urandom);
            bus.dp_b     = 8'($urandom);
            bus.digit_en = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            for (int c = 0, len = $urandom_range(10, 80); c < len; c++) begin
                if ($urandom_range(0, 7) == 0)
                    bus.data_a[4*$urandom_range(0, 7) +: 4] = 4'($urandom);
                if ($urandom_range(0, 19) == 0)
                    bus.req_b = ~bus.req_b;
                rst = ($urandom_range(0, 399) == 0);
                step(1);
            end
        end
        rst = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
